// File: rtl/mem_pkg.sv
// Shared types and address-check helpers for the two-port memory arbiter.
// Also holds the state and port-id enums used by mem_arbiter and rr_arb2.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Port id doubles as the bit index into the 2-bit request/grant vectors
    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    localparam logic [1:0]  ALIGN_MASK = 2'b11;
    localparam logic [63:0] WORD_BYTES = 64'd4;

    function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] mem_size);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (addr > (mem_size - WORD_BYTES));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and a tie goes
// to the port that was not granted last. last_r changes only when update is high.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    port_t last_r;

    // Grant selection from the current requests and the last winner
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last_r == PORT_FETCH) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= PORT_FETCH;
        end else if (update) begin
            last_r <= gnt[1] ? PORT_DATA : PORT_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto a single-ported memory.
// Each request is either one memory access cycle or an immediate fault response.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 f_req_valid_i,
    output logic                 f_req_ready_o,
    input  logic [WORD_SIZE-1:0] f_addr_i,
    output logic                 f_resp_valid_o,
    input  logic                 f_resp_ready_i,
    output logic [WORD_SIZE-1:0] f_rdata_o,
    output logic                 f_err_o,
    input  logic                 d_req_valid_i,
    output logic                 d_req_ready_o,
    input  logic                 d_we_i,
    input  logic [WORD_SIZE-1:0] d_addr_i,
    input  logic [WORD_SIZE-1:0] d_wdata_i,
    output logic                 d_resp_valid_o,
    input  logic                 d_resp_ready_i,
    output logic [WORD_SIZE-1:0] d_rdata_o,
    output logic                 d_err_o,
    output logic                 en_mem_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [WORD_SIZE-1:0] addr_base_o,
    output logic [WORD_SIZE-1:0] addr_offset_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);

    state_t               state_r, state_nx_s;
    port_t                port_r, port_nx_s;
    logic                 we_r, we_nx_s;
    logic [WORD_SIZE-1:0] addr_r, addr_nx_s, wdata_r, wdata_nx_s, rdata_r;
    logic                 err_r;
    logic                 en_mem_r, mem_read_r, mem_write_r;
    logic                 f_resp_valid_r, d_resp_valid_r;
    logic [1:0]           req_s, gnt_s;
    logic                 req_hs_s, resp_hs_s, fault_s;
    logic [WORD_SIZE-1:0] req_addr_s;

    rr_arb2 u_rr_arb2 (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (req_s),
        .update (req_hs_s),
        .gnt    (gnt_s)
    );

    // Request side: ready only in IDLE toward the granted port
    always_comb begin
        req_s         = {d_req_valid_i, f_req_valid_i};
        f_req_ready_o = 1'b0;
        d_req_ready_o = 1'b0;
        if (state_r == ST_IDLE) begin
            f_req_ready_o = gnt_s[0];
            d_req_ready_o = gnt_s[1];
        end else begin
            f_req_ready_o = 1'b0;
            d_req_ready_o = 1'b0;
        end
        req_hs_s   = (state_r == ST_IDLE) && (gnt_s != 2'b00);
        req_addr_s = gnt_s[1] ? d_addr_i : f_addr_i;
        fault_s    = addr_fault(64'(req_addr_s), 64'(MEM_SIZE));
        if (port_r == PORT_DATA) begin
            resp_hs_s = d_resp_valid_r & d_resp_ready_i;
        end else begin
            resp_hs_s = f_resp_valid_r & f_resp_ready_i;
        end
    end

    // Next-state and next transaction fields
    always_comb begin
        state_nx_s = state_r;
        port_nx_s  = port_r;
        we_nx_s    = we_r;
        addr_nx_s  = addr_r;
        wdata_nx_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    port_nx_s  = gnt_s[1] ? PORT_DATA : PORT_FETCH;
                    we_nx_s    = gnt_s[1] & d_we_i;
                    addr_nx_s  = req_addr_s;
                    wdata_nx_s = gnt_s[1] ? d_wdata_i : {WORD_SIZE{1'b0}};
                    state_nx_s = fault_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nx_s = ST_RESP;
            ST_RESP: begin
                if (resp_hs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, latched request, and outputs registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            port_r         <= PORT_FETCH;
            we_r           <= 1'b0;
            addr_r         <= {WORD_SIZE{1'b0}};
            wdata_r        <= {WORD_SIZE{1'b0}};
            rdata_r        <= {WORD_SIZE{1'b0}};
            err_r          <= 1'b0;
            en_mem_r       <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            f_resp_valid_r <= 1'b0;
            d_resp_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            port_r         <= port_nx_s;
            we_r           <= we_nx_s;
            addr_r         <= addr_nx_s;
            wdata_r        <= wdata_nx_s;
            en_mem_r       <= (state_nx_s == ST_ACCESS);
            mem_read_r     <= (state_nx_s == ST_ACCESS) && !we_nx_s;
            mem_write_r    <= (state_nx_s == ST_ACCESS) && we_nx_s;
            f_resp_valid_r <= (state_nx_s == ST_RESP) && (port_nx_s == PORT_FETCH);
            d_resp_valid_r <= (state_nx_s == ST_RESP) && (port_nx_s == PORT_DATA);
            // Stores and faults answer with zero data; loads fill it at the end of ACCESS
            if (req_hs_s) begin
                rdata_r <= {WORD_SIZE{1'b0}};
                err_r   <= fault_s;
            end else if ((state_r == ST_ACCESS) && !we_r) begin
                rdata_r <= mem_rdata_i;
            end
        end
    end

    assign f_resp_valid_o = f_resp_valid_r;
    assign d_resp_valid_o = d_resp_valid_r;
    assign f_rdata_o      = rdata_r;
    assign d_rdata_o      = rdata_r;
    assign f_err_o        = err_r;
    assign d_err_o        = err_r;
    assign en_mem_o       = en_mem_r;
    assign mem_read_o     = mem_read_r;
    assign mem_write_o    = mem_write_r;
    assign addr_base_o    = addr_r;
    assign addr_offset_o  = {WORD_SIZE{1'b0}};
    assign mem_wdata_o    = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1 KiB memory behind it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        f_req_valid, f_req_ready_o, f_resp_valid_o, f_resp_ready, f_err_o;
    logic [31:0] f_addr, f_rdata_o;
    logic        d_req_valid, d_req_ready_o, d_we, d_resp_valid_o, d_resp_ready, d_err_o;
    logic [31:0] d_addr, d_wdata, d_rdata_o;
    logic        en_mem_o, mem_read_o, mem_write_o;
    logic [31:0] addr_base_o, addr_offset_o, mem_wdata_o, mem_rdata;
    logic [31:0] mem_model [0:255];

    int pass_cnt = 0;
    int total_cnt = 0;
    int en_cnt = 0;
    int strobe_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(32), .MEM_SIZE(1024)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .f_req_valid_i(f_req_valid), .f_req_ready_o(f_req_ready_o), .f_addr_i(f_addr),
        .f_resp_valid_o(f_resp_valid_o), .f_resp_ready_i(f_resp_ready),
        .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready_o), .d_we_i(d_we),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_resp_valid_o(d_resp_valid_o), .d_resp_ready_i(d_resp_ready),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .en_mem_o(en_mem_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .addr_base_o(addr_base_o), .addr_offset_o(addr_offset_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) if (en_mem_o && mem_write_o) mem_model[addr_base_o[9:2]] <= mem_wdata_o;
    assign mem_rdata = mem_model[addr_base_o[9:2]];

    always @(negedge clk) begin
        if (en_mem_o) en_cnt++;
        if (!en_mem_o && (mem_read_o || mem_write_o)) strobe_bad++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    // One request on the chosen port; lat counts edges from handshake to resp_valid
    task automatic txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat, output int ens);
        int e0;
        int w;
        @(negedge clk);
        e0 = en_cnt;
        if (is_d) begin
            d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req_valid = 1'b1; f_addr = addr;
        end
        #1;
        w = 0;
        while (!(is_d ? d_req_ready_o : f_req_ready_o) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        f_req_valid = 1'b0;
        lat = 1;
        while (!(is_d ? d_resp_valid_o : f_resp_valid_o) && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        rdata = is_d ? d_rdata_o : f_rdata_o;
        err   = is_d ? d_err_o : f_err_o;
        @(posedge clk);
        #1;
        ens = en_cnt - e0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b1;
        f_req_valid = 1'b1;
        d_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        f_req_valid = 1'b0;
        d_req_valid = 1'b0;
        #1;
        total_cnt++; if (en_mem_o !== 1'b0) $display("FAIL rst_en: got %b exp 0", en_mem_o); else pass_cnt++;
        total_cnt++; if ({f_resp_valid_o, d_resp_valid_o} !== 2'b00) $display("FAIL rst_resp_valid: got %b exp 00", {f_resp_valid_o, d_resp_valid_o}); else pass_cnt++;
        total_cnt++; if (addr_base_o !== 32'h0) $display("FAIL rst_addr: got %h exp 0", addr_base_o); else pass_cnt++;
        total_cnt++; if (d_rdata_o !== 32'h0) $display("FAIL rst_rdata: got %h exp 0", d_rdata_o); else pass_cnt++;
        rst_i = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; int ens;
        txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, ens);
        total_cnt++; if (lat !== 2) $display("FAIL st_lat: got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL st_err: got %b exp 0", er); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0) $display("FAIL st_rdata: got %h exp 0", rd); else pass_cnt++;
        total_cnt++; if (ens !== 1) $display("FAIL st_en_pulses: got %0d exp 1", ens); else pass_cnt++;
        total_cnt++; if (d_resp_valid_o !== 1'b0) $display("FAIL st_one_cycle_resp: got %b exp 0", d_resp_valid_o); else pass_cnt++;
        txn(1'b1, 1'b0, 32'h10, 32'h0, rd, er, lat, ens);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata: got %h exp deadbeef", rd); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL ld_err: got %b exp 0", er); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL ld_lat: got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (ens !== 1) $display("FAIL ld_en_pulses: got %0d exp 1", ens); else pass_cnt++;
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, ens);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got %h exp deadbeef", rd); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL fetch_lat: got %0d exp 2", lat); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [3];
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            f_req_valid = 1'b1; f_addr = 32'h20;
            d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h24;
            #1;
            total_cnt++;
            if ({d_req_ready_o, f_req_ready_o} !== exp_gnt[k])
                $display("FAIL rr_grant%0d: got %b exp %b", k, {d_req_ready_o, f_req_ready_o}, exp_gnt[k]);
            else pass_cnt++;
            @(posedge clk);
            #1;
            f_req_valid = 1'b0;
            d_req_valid = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_back_pressure();
        int w;
        do_reset();
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        f_req_valid = 1'b1; f_addr = 32'h10;
        d_resp_ready = 1'b0;
        #1;
        total_cnt++; if (d_req_ready_o !== 1'b1) $display("FAIL bp_d_first: got %b exp 1", d_req_ready_o); else pass_cnt++;
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (d_resp_valid_o !== 1'b1) $display("FAIL bp_valid%0d: got %b exp 1", i, d_resp_valid_o); else pass_cnt++;
            total_cnt++; if (d_rdata_o !== 32'hDEADBEEF) $display("FAIL bp_rdata%0d: got %h exp deadbeef", i, d_rdata_o); else pass_cnt++;
            total_cnt++; if (f_req_ready_o !== 1'b0) $display("FAIL bp_f_ready%0d: got %b exp 0", i, f_req_ready_o); else pass_cnt++;
            @(posedge clk);
            #1;
        end
        d_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (d_resp_valid_o !== 1'b0) $display("FAIL bp_release: got %b exp 0", d_resp_valid_o); else pass_cnt++;
        total_cnt++; if (f_req_ready_o !== 1'b1) $display("FAIL bp_f_held: got %b exp 1", f_req_ready_o); else pass_cnt++;
        @(posedge clk);
        #1;
        f_req_valid = 1'b0;
        w = 0;
        while (!f_resp_valid_o && w < 10) begin
            @(posedge clk); #1; w++;
        end
        total_cnt++; if (f_resp_valid_o !== 1'b1) $display("FAIL bp_f_resp: got %b exp 1", f_resp_valid_o); else pass_cnt++;
        total_cnt++; if (f_rdata_o !== 32'hDEADBEEF) $display("FAIL bp_f_rdata: got %h exp deadbeef", f_rdata_o); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic er; int lat; int ens;
        txn(1'b1, 1'b0, 32'h13, 32'h0, rd, er, lat, ens);
        total_cnt++; if ({er, lat[3:0]} !== {1'b1, 4'd1}) $display("FAIL flt_misalign: got err=%b lat=%0d exp err=1 lat=1", er, lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0) $display("FAIL flt_misalign_rdata: got %h exp 0", rd); else pass_cnt++;
        total_cnt++; if (ens !== 0) $display("FAIL flt_misalign_en: got %0d exp 0", ens); else pass_cnt++;
        txn(1'b0, 1'b0, 32'd1022, 32'h0, rd, er, lat, ens);
        total_cnt++; if ({er, lat[3:0]} !== {1'b1, 4'd1}) $display("FAIL flt_fetch_top: got err=%b lat=%0d exp err=1 lat=1", er, lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0) $display("FAIL flt_fetch_rdata: got %h exp 0", rd); else pass_cnt++;
        total_cnt++; if (ens !== 0) $display("FAIL flt_fetch_en: got %0d exp 0", ens); else pass_cnt++;
        txn(1'b1, 1'b1, 32'h400, 32'h55AA55AA, rd, er, lat, ens);
        total_cnt++; if ({er, ens[3:0]} !== {1'b1, 4'd0}) $display("FAIL flt_past_end: got err=%b en=%0d exp err=1 en=0", er, ens); else pass_cnt++;
        txn(1'b1, 1'b1, 32'h3FC, 32'h12345678, rd, er, lat, ens);
        total_cnt++; if ({er, lat[3:0]} !== {1'b0, 4'd2}) $display("FAIL last_word_st: got err=%b lat=%0d exp err=0 lat=2", er, lat); else pass_cnt++;
        txn(1'b0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, ens);
        total_cnt++; if (rd !== 32'h12345678) $display("FAIL last_word_ld: got %h exp 12345678", rd); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int ens; int seen;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        total_cnt++; if (en_mem_o !== 1'b1) $display("FAIL abort_in_access: got %b exp 1", en_mem_o); else pass_cnt++;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        total_cnt++; if (en_mem_o !== 1'b0) $display("FAIL abort_en: got %b exp 0", en_mem_o); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (d_resp_valid_o || f_resp_valid_o || en_mem_o) seen++;
            @(posedge clk);
            #1;
        end
        total_cnt++; if (seen !== 0) $display("FAIL abort_no_resp: got %0d active cycles exp 0", seen); else pass_cnt++;
        txn(1'b1, 1'b0, 32'h10, 32'h0, rd, er, lat, ens);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL abort_reload: got %h exp deadbeef", rd); else pass_cnt++;
        total_cnt++; if ({er, lat[3:0]} !== {1'b0, 4'd2}) $display("FAIL abort_reload_lat: got err=%b lat=%0d exp err=0 lat=2", er, lat); else pass_cnt++;
        total_cnt++; if (strobe_bad !== 0) $display("FAIL strobe_idle: got %0d exp 0", strobe_bad); else pass_cnt++;
    endtask

    initial begin
        rst_i = 1'b1;
        f_req_valid = 1'b0; f_addr = 32'h0; f_resp_ready = 1'b1;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_round_robin();
        test_back_pressure();
        test_fault();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, data/address width in bits.
REQ-002 Parameter MEM_SIZE, default 1024, byte capacity of the attached memory.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 f_req_valid_i  input  1  fetch requester: read request valid.
REQ-006 f_req_ready_o  output  1  fetch request accepted this cycle.
REQ-007 f_addr_i  input  WORD_SIZE  fetch byte address.
REQ-008 f_resp_valid_o  output  1  fetch response valid.
REQ-009 f_resp_ready_i  input  1  fetch requester can take the response.
REQ-010 f_rdata_o  output  WORD_SIZE  fetch read data.
REQ-011 f_err_o  output  1  fetch access fault, qualified by f_resp_valid_o.
REQ-012 d_req_valid_i  input  1  data requester: load/store request valid.
REQ-013 d_req_ready_o  output  1  data request accepted this cycle.
REQ-014 d_we_i  input  1  1 = store, 0 = load.
REQ-015 d_addr_i  input  WORD_SIZE  data byte address.
REQ-016 d_wdata_i  input  WORD_SIZE  store data.
REQ-017 d_resp_valid_o / d_resp_ready_i / d_rdata_o / d_err_o  output/input/output/output  1/1/WORD_SIZE/1  data response; same rules as the fetch response.
REQ-018 en_mem_o, mem_read_o, mem_write_o  output  1 each  memory enable and command strobes.
REQ-019 addr_base_o, addr_offset_o  output  WORD_SIZE  memory address; offset is driven to 0.
REQ-020 mem_wdata_o  output  WORD_SIZE  write data to memory; mem_rdata_i  input  WORD_SIZE  combinational read data from memory.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-022 In IDLE, the arbiter SHALL assert at most one of f_req_ready_o/d_req_ready_o, only toward a valid requester; a handshake occurs when valid and ready are both high; on handshake, latch addr/we/wdata/port -> ACCESS.
REQ-023 Arbitration SHALL be round-robin on a last_grant bit: with both requests valid, grant the port not granted last; the last_grant reset value SHALL be fetch, so data wins the first tie.
REQ-024 A fault SHALL occur when addr[1:0]!=0 or addr > MEM_SIZE-4; a faulting request SHALL still handshake, SHALL skip ACCESS, and SHALL go directly to RESP with err=1 and rdata=0; memory strobes SHALL stay 0.
REQ-025 In ACCESS, the arbiter SHALL assert en_mem_o=1 for exactly one cycle, with mem_read_o=!we, mem_write_o=we, and address/wdata stable; when the operation is a load, mem_rdata_i SHALL be captured at the end of the cycle; next state is RESP.
REQ-026 en_mem_o SHALL be 0 in every cycle outside ACCESS, so that each access presents exactly one rising edge to the memory; mem_read_o/mem_write_o SHALL be 0 when en_mem_o=0.
REQ-027 In RESP, the arbiter SHALL hold resp_valid high on the granted port only, with rdata/err stable until resp_ready; for a store, rdata SHALL be 0; on the handshake, transition to IDLE.
REQ-028 Latency from request handshake to resp_valid SHALL be 2 cycles for a normal access and 1 cycle for a faulting access; throughput SHALL be at most one request per 3 cycles.
REQ-029 Requests arriving while the FSM is not in IDLE SHALL see ready=0 and SHALL NOT be dropped; the requester holds valid.
REQ-030 When resp_ready is already high on entry to RESP, the response SHALL complete in one cycle.

Reset
REQ-031 Reset SHALL set the state to IDLE and last_grant to fetch, and SHALL clear all outputs, latched fields and captured data.
REQ-032 Reset during ACCESS or RESP SHALL abort the transaction: en_mem_o=0 in the next cycle, and no response is issued.

Structure
REQ-033 The state enum, the port-id enum and the alignment/bound helper constants SHALL live in a shared package, mem_pkg.
REQ-034 The tie-break logic SHALL be isolated in one sub-module, rr_arb2, a 2-way round-robin arbiter with a grant-update input; everything else SHALL stay flat.

Verification
REQ-035 Store d_addr=0x10, wdata=0xDEADBEEF, then load d_addr=0x10 -> one en_mem_o pulse per op; d_rdata_o=0xDEADBEEF, d_err_o=0.
REQ-036 f and d valid in the same cycle after reset, three times in a row -> grants in the order d, f, d.
REQ-037 Load d_addr=0x13 and fetch f_addr=MEM_SIZE-2 -> resp 1 cycle after handshake, err=1, rdata=0, en_mem_o never high.
REQ-038 d_resp_ready_i held low 5 cycles -> d_resp_valid_o and data stable for 5 cycles; f_req_ready_o=0 throughout.
REQ-039 rst_i asserted in the ACCESS cycle of a store -> IDLE next cycle; no response; a following load still returns the correct data.
